// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: op encodings,
// FSM state codes, default datapath width and iteration counter width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ITER = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return !((op == OP_MULT) || (op == OP_MULTU));
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift for multiply, restoring subtract-shift for
// divide. The divide half exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;

  // Multiply: conditional add into the high half, carry kept as the extra bit.
  always_comb begin
    if (acc_lo[0]) begin
      sum_s = {1'b0, acc_hi} + {1'b0, opnd};
    end else begin
      sum_s = {1'b0, acc_hi};
    end
    mul_hi_s = sum_s[WIDTH:1];
    mul_lo_s = {sum_s[0], acc_lo[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Divide: remainder fits WIDTH bits after a successful subtract, so the
  // difference is taken modulo 2^WIDTH.
  always_comb begin
    rem_sh_s = {acc_hi, acc_lo[WIDTH-1]};
    ge_s     = (rem_sh_s >= {1'b0, opnd});
    diff_s   = rem_sh_s[WIDTH-1:0] - opnd;
    if (is_div) begin
      nxt_hi = ge_s ? diff_s : rem_sh_s[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge_s};
    end else begin
      nxt_hi = mul_hi_s;
      nxt_lo = mul_lo_s;
    end
  end
`else
  // Multiply-only build.
  always_comb begin
    nxt_hi = mul_hi_s;
    nxt_lo = mul_lo_s;
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owning multiply/divide sequencer: FSM, iteration counter, sign latches.
// Divide hardware is present only when MULDIV_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               sgn_q_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_out_r;
`ifdef MULDIV_DIV_EN
  logic               is_div_r;
  logic               sgn_r_r;
  logic               dz_r;
`endif

  logic               is_div_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH-1:0]   acc_lo_ld_s;
  logic [WIDTH-1:0]   opnd_ld_s;
  logic               start_iter_s;
  logic               div_stub_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Operand magnitudes and start decode.
  always_comb begin
    is_div_s = op_is_div(op);
    a_neg_s  = op_is_signed(op) & a[WIDTH-1];
    b_neg_s  = op_is_signed(op) & b[WIDTH-1];
    a_abs_s  = a_neg_s ? -a : a;
    b_abs_s  = b_neg_s ? -b : b;
`ifdef MULDIV_DIV_EN
    start_iter_s = start;
    div_stub_s   = 1'b0;
`else
    start_iter_s = start & ~is_div_s;
    div_stub_s   = start & is_div_s;
`endif
  end

  // Accumulator/operand load values for the first iteration.
  always_comb begin
`ifdef MULDIV_DIV_EN
    if (is_div_s) begin
      // A zero divisor runs on the raw dividend so it falls out unchanged in HI.
      acc_lo_ld_s = (b == '0) ? a : a_abs_s;
      opnd_ld_s   = b_abs_s;
    end else begin
      acc_lo_ld_s = b_abs_s;
      opnd_ld_s   = a_abs_s;
    end
`else
    acc_lo_ld_s = b_abs_s;
    opnd_ld_s   = a_abs_s;
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div (is_div_r),
`endif
    .acc_hi (acc_hi_r),
    .acc_lo (acc_lo_r),
    .opnd   (opnd_r),
    .nxt_hi (step_hi_s),
    .nxt_lo (step_lo_s)
  );

  // Sign correction and HI/LO selection applied in FIX.
  always_comb begin
    prod_s   = sgn_q_r ? -{acc_hi_r, acc_lo_r} : {acc_hi_r, acc_lo_r};
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_r) begin
      if (dz_r) begin
        fix_hi_s = acc_hi_r;
        fix_lo_s = acc_lo_r;
      end else begin
        fix_hi_s = sgn_r_r ? -acc_hi_r : acc_hi_r;
        fix_lo_s = sgn_q_r ? -acc_lo_r : acc_lo_r;
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
`endif
  end

  // Sequencer FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      opnd_r   <= '0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      sgn_q_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_r <= 1'b0;
      sgn_r_r  <= 1'b0;
      dz_r     <= 1'b0;
`endif
    end else begin
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_iter_s) begin
            state_r  <= S_ITER;
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            acc_hi_r <= '0;
            acc_lo_r <= acc_lo_ld_s;
            opnd_r   <= opnd_ld_s;
            sgn_q_r  <= a_neg_s ^ b_neg_s;
`ifdef MULDIV_DIV_EN
            is_div_r <= is_div_s;
            sgn_r_r  <= a_neg_s;
            dz_r     <= is_div_s & (b == '0);
`endif
          end else if (div_stub_s) begin
            done_r   <= 1'b1;
            dz_out_r <= 1'b1;
          end else begin
            // MT writes lose to a same-cycle start.
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
          end
        end
        S_ITER: begin
          if (abort) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
            cnt_r    <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) state_r <= S_FIX;
          end
        end
        S_FIX: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          if (!abort) begin
            hi_r     <= fix_hi_s;
            lo_r     <= fix_lo_s;
            done_r   <= 1'b1;
`ifdef MULDIV_DIV_EN
            dz_out_r <= dz_r;
`endif
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign dz   = dz_out_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; divide expectations follow
// whether MULDIV_DIV_EN is defined.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        abort = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      tick();
      cyc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || dz !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", done, dz); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h_%h want=0_0", hi, lo); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_multu();
    int cyc; bit seen;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b want=1", busy); end
    run_to_done(cyc, seen);
    total++; if (!seen || cyc != 33) begin bad++; $display("FAIL multu_latency got=%0d seen=%0d want=33", cyc, seen); end
    total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_result got=%h_%h want=fffffffe_00000001", hi, lo); end
    total++; if (busy !== 1'b0 || dz !== 1'b0) begin bad++; $display("FAIL multu_flags busy=%b dz=%b want=0,0", busy, dz); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_mult();
    int cyc; bit seen;
    logic [31:0] xa [3] = '{32'hFFFF_FFFD, 32'h1234_5678, 32'hFFFF_FFFE};
    logic [31:0] xb [3] = '{32'h0000_0007, 32'h0000_0010, 32'hFFFF_FFFD};
    logic [31:0] eh [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] el [3] = '{32'hFFFF_FFEB, 32'h2345_6780, 32'h0000_0006};
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, xa[i], xb[i]);
      run_to_done(cyc, seen);
      total++;
      if (!seen || hi !== eh[i] || lo !== el[i]) begin
        bad++; $display("FAIL mult_%0d got=%h_%h seen=%0d want=%h_%h", i, hi, lo, seen, eh[i], el[i]);
      end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int cyc; bit seen;
    logic [1:0]  vo [5] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] xa [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd5, 32'hFFFF_FFF8};
    logic [31:0] xb [5] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0};
    logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'h0, 32'd2, 32'd5, 32'hFFFF_FFF8};
    logic [31:0] el [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        ez [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(vo[i], xa[i], xb[i]);
      run_to_done(cyc, seen);
      total++;
      if (!seen || cyc != 33 || hi !== eh[i] || lo !== el[i] || dz !== ez[i]) begin
        bad++; $display("FAIL div_%0d got=%h_%h dz=%b cyc=%0d want=%h_%h dz=%b cyc=33", i, hi, lo, dz, cyc, eh[i], el[i], ez[i]);
      end
    end
    tick();
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL div_dz_pulse got=%b want=0", dz); end
  endtask
`else
  task automatic test_div();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_0001;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    issue(2'b11, 32'd5, 32'd0);
    total++; if (done !== 1'b1 || dz !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL nodiv_flags got done=%b dz=%b busy=%b want=1,1,0", done, dz, busy); end
    total++; if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001) begin bad++; $display("FAIL nodiv_hilo got=%h_%h want=cafe0001_cafe0001", hi, lo); end
    tick();
    total++; if (done !== 1'b0 || dz !== 1'b0) begin bad++; $display("FAIL nodiv_pulse got=%b%b want=00", done, dz); end
  endtask
`endif

  task automatic test_abort();
    int cyc; bit seen;
    issue(2'b01, 32'd3, 32'd4);
    run_to_done(cyc, seen);
    issue(2'b00, 32'd5, 32'd6);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b want=0", busy); end
    run_to_done(cyc, seen);
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", seen); end
    total++; if (hi !== 32'd0 || lo !== 32'd12) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0_c", hi, lo); end
    mthi = 1'b1; wdata = 32'h0000_1234;
    tick();
    mthi = 1'b0;
    total++; if (hi !== 32'h0000_1234 || lo !== 32'd12) begin bad++; $display("FAIL mthi got=%h_%h want=1234_c", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    issue(2'b01, 32'd2, 32'd3);
    run_to_done(cyc, seen);
    total++; if (!seen || lo !== 32'd6) begin bad++; $display("FAIL b2b_first got=%h seen=%0d want=6", lo, seen); end
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b want=1", busy); end
    repeat (5) tick();
    start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1; mtlo = 1'b1; wdata = 32'h0000_0BAD;
    tick();
    start = 1'b0; mtlo = 1'b0;
    run_to_done(cyc, seen);
    total++; if (!seen || cyc != 27) begin bad++; $display("FAIL b2b_latency got=%0d seen=%0d want=27", cyc, seen); end
    total++; if (hi !== 32'd1 || lo !== 32'd0) begin bad++; $display("FAIL b2b_result got=%h_%h want=1_0", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen;
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    repeat (19) tick();
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL midreset got busy=%b done=%b dz=%b hilo=%h_%h want all 0", busy, done, dz, hi, lo);
    end
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7; mtlo = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    start = 1'b0; mtlo = 1'b0;
    total++; if (lo !== 32'h0 || busy !== 1'b1) begin bad++; $display("FAIL mtlo_drop got lo=%h busy=%b want=0,1", lo, busy); end
    run_to_done(cyc, seen);
    total++; if (!seen || hi !== 32'h0 || lo !== 32'd42) begin bad++; $display("FAIL start_mtlo got=%h_%h seen=%0d want=0_2a", hi, lo, seen); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the integer datapath. It accepts MULT/MULTU/DIV/DIVU requests from the execute stage and runs a radix-2 shift/add (multiply) or restoring shift/subtract (divide) over 32 iterations. It applies sign correction and writes HI/LO. It raises `busy` so the hazard logic stalls MFHI/MFLO/MTHI/MTLO and further mul/div issue. It sits beside the ALU in EX, fed by the same operand buses and decoded op field.

## Interface
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (multiplicand / dividend).
- `b` in WIDTH: rt operand (multiplier / divisor).
- `abort` in 1: flush; cancels the running operation.
- `mthi`, `mtlo` in 1: direct writes of `wdata` into HI/LO.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO updated on the same edge.
- `dz` out 1: divide-by-zero flag, valid with `done`.
- `hi`, `lo` out WIDTH: architectural HI/LO.

## Operation
- States: IDLE, ITER, FIX.
- IDLE with `start`=1:
  - latch the op;
  - latch |a|, |b| for signed ops (operands raw for unsigned ops);
  - latch result-sign bits: product/quotient sign = a[31]^b[31]; remainder sign = a[31];
  - latch `dz` = (div op && b==0);
  - clear the 6-bit counter; go to ITER.
- ITER, multiply: if acc_lo[0], add the multiplicand to acc_hi; shift {carry,acc_hi,acc_lo} right by 1.
- ITER, divide: shift {rem,quo} left by 1; trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
- Counter increments each cycle. Leave ITER after WIDTH iterations, moving to FIX.
- FIX:
  - signed ops apply two's-complement negation per the latched sign bits;
  - write HI/LO: mult HI=product[63:32], LO=product[31:0]; div LO=quotient, HI=remainder;
  - assert `done`; return to IDLE.
- Divide by zero: HI=a (original, unsigned view), LO=all ones, `dz`=1. Still takes full latency.
- Signed overflow (−2^31 / −1): LO=0x8000_0000, HI=0. No flag.
- `abort` in ITER or FIX: return to IDLE next edge. HI/LO untouched, no `done`. `abort` in IDLE has no effect.
- `mthi`/`mtlo` are accepted only in IDLE. While `busy` they are ignored; the pipeline must stall them.
- `start` with `mthi`/`mtlo` in the same IDLE cycle: start taken, MT write dropped.
- `start` while `busy`: ignored.

## Timing
- Reset (async, `reset_n`=0): state IDLE; `busy`=0, `done`=0, `dz`=0, `hi`=0, `lo`=0; counter and accumulators 0.
- Start sampled at edge E0. `busy`=1 after E0. ITER occupies E1..E32. FIX at E33 writes HI/LO and sets `done`=1 and `busy`=0.
- Latency: 33 cycles from start edge to result.
- `done` and `dz` are registered and high for exactly one cycle. `dz` is otherwise 0.
- Back-to-back: `start` in the cycle `done`=1 is accepted (state IDLE then).
- MTHI/MTLO: HI/LO updated at the next edge; visible the following cycle.
- `abort` has priority over the iteration step at the same edge.

## Configuration
- `MULDIV_DIV_EN` defined: full divide path as above.
- `MULDIV_DIV_EN` undefined:
  - divide hardware removed;
  - DIV/DIVU complete in IDLE at the start edge with HI/LO unchanged;
  - `done`=1 and `dz`=1 next cycle;
  - `busy` never asserts for divides.
- Multiply is unaffected.

## Structure
- `muldiv_pkg`:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (S_IDLE, S_ITER, S_FIX);
  - default WIDTH and counter width.
- Sub-module `muldiv_step`: combinational single-iteration add-shift / subtract-shift cell.
- The sequencer holds the FSM, counter, sign latches and HI/LO.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> after 33 cycles HI=0xFFFF_FFFE, LO=0x0000_0001, `done` pulse.
- MULT a=−3 (0xFFFF_FFFD), b=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- DIV a=−7, b=2 -> LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1); DIV a=0x8000_0000, b=−1 -> LO=0x8000_0000, HI=0.
- DIVU a=5, b=0 -> HI=5, LO=0xFFFF_FFFF, `dz`=1 with `done`; same with macro undefined -> HI/LO unchanged, `dz`=1 one cycle after start.
- Abort: `abort` 10 cycles after start -> IDLE next cycle, no `done`, HI/LO keep prior values. Then MTHI 0x1234 -> HI=0x1234.
- Reset mid-operation at cycle 20 -> all outputs 0 immediately. Then start on the same cycle as `mtlo` -> mtlo dropped, multiply result written.
